// File: rtl/fsmc_write_rx.sv
// FSMC write receiver: synchronizes the MCU write strobe, filters glitches,
// and routes command words to cmd_code and data words into a FWFT FIFO.
//
// Ports:
//   clk_80mhz, rst_n       - single clock, async active-low reset
//   fsmc_nwe/cle/d_in      - asynchronous FSMC write-side pins (input only)
//   wr_data/valid/ready    - FWFT FIFO head and pop handshake
//   cmd_code, cmd_strobe   - last command word and its one-cycle update pulse
//   fifo_level, overflow   - words held and sticky drop flag
//   ovf_clear              - clears overflow (a same-cycle set wins)
module fsmc_write_rx #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] FLUSH_CMD  = 16'hC1EA
) (
    input  logic                          clk_80mhz,
    input  logic                          rst_n,
    input  logic                          fsmc_nwe,
    input  logic                          fsmc_cle,
    input  logic [15:0]                   fsmc_d_in,
    output logic [15:0]                   wr_data,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [15:0]                   cmd_code,
    output logic                          cmd_strobe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clear
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        COMMIT
    } state_t;

    // Synchronizers: all three paths share the same depth so data and
    // cle stay aligned with the strobe they belong to.
    logic [1:0]  nwe_sync;
    logic [1:0]  cle_sync;
    logic [15:0] d_sync1;
    logic [15:0] d_sync2;
    logic        nwe_s;
    logic        cle_s;
    logic [15:0] d_s;

    always_ff @(posedge clk_80mhz or negedge rst_n) begin
        if (!rst_n) begin
            nwe_sync <= 2'b11;
            cle_sync <= 2'b00;
            d_sync1  <= '0;
            d_sync2  <= '0;
        end else begin
            nwe_sync <= {nwe_sync[0], fsmc_nwe};
            cle_sync <= {cle_sync[0], fsmc_cle};
            d_sync1  <= fsmc_d_in;
            d_sync2  <= d_sync1;
        end
    end

    assign nwe_s = nwe_sync[1];
    assign cle_s = cle_sync[1];
    assign d_s   = d_sync2;

    // Strobe FSM
    state_t      state;
    logic [1:0]  low_cnt;
    logic        cle_l;
    logic [15:0] d_l;

    always_ff @(posedge clk_80mhz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            low_cnt    <= '0;
            cle_l      <= 1'b0;
            d_l        <= '0;
            cmd_code   <= '0;
            cmd_strobe <= 1'b0;
        end else begin
            cmd_strobe <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!nwe_s) begin
                        state   <= LOW;
                        low_cnt <= '0;
                    end
                end
                LOW: begin
                    // Keep sampling until the strobe rises; the word
                    // committed is the last one seen while still in LOW.
                    d_l   <= d_s;
                    cle_l <= cle_s;
                    if (low_cnt != 2'd3) begin
                        low_cnt <= low_cnt + 2'd1;
                    end
                    if (nwe_s) begin
                        // Too short a low phase is treated as a glitch.
                        state <= (low_cnt >= 2'd2) ? COMMIT : IDLE;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (cle_l) begin
                        cmd_code   <= d_l;
                        cmd_strobe <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Commit decode
    logic commit;
    logic cmd_commit;
    logic data_commit;
    logic flush;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign commit      = (state == COMMIT);
    assign cmd_commit  = commit & cle_l;
    assign data_commit = commit & ~cle_l;
    assign flush       = cmd_commit & (d_l == FLUSH_CMD);

    assign full = (fifo_level == LW'(FIFO_DEPTH));
    assign pop  = wr_valid & wr_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = data_commit & (~full | pop);
    assign drop = data_commit & full & ~pop;

    // FIFO storage
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk_80mhz) begin
        if (push) begin
            mem[wr_ptr] <= d_l;
        end
    end

    always_ff @(posedge clk_80mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            // Flush outranks any pop requested this cycle.
            rd_ptr     <= wr_ptr;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LW'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk_80mhz or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= drop | (overflow & ~ovf_clear);
        end
    end

    assign wr_valid = (fifo_level != '0);
    assign wr_data  = wr_valid ? mem[rd_ptr] : 16'h0000;

endmodule

// File: tb/tb_fsmc_write_rx.sv
// Bench for fsmc_write_rx: queue-based reference model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_fsmc_write_rx;

    localparam int DEPTH = 16;
    localparam logic [15:0] FLUSH = 16'hC1EA;

    logic        clk_80mhz = 1'b0;
    logic        rst_n     = 1'b0;
    logic        fsmc_nwe  = 1'b1;
    logic        fsmc_cle  = 1'b0;
    logic [15:0] fsmc_d_in = 16'h0;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready  = 1'b0;
    logic [15:0] cmd_code;
    logic        cmd_strobe;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        ovf_clear = 1'b0;

    fsmc_write_rx #(
        .FIFO_DEPTH(DEPTH),
        .FLUSH_CMD (FLUSH)
    ) dut (
        .clk_80mhz (clk_80mhz),
        .rst_n     (rst_n),
        .fsmc_nwe  (fsmc_nwe),
        .fsmc_cle  (fsmc_cle),
        .fsmc_d_in (fsmc_d_in),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .cmd_code  (cmd_code),
        .cmd_strobe(cmd_strobe),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .ovf_clear (ovf_clear)
    );

    always #5 clk_80mhz = ~clk_80mhz;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: commits are scheduled by the writer at the cycle
    // the latency rule predicts; the FIFO itself is a plain queue.
    typedef struct {
        int          cyc;
        logic        cle;
        logic [15:0] d;
    } ev_t;

    ev_t         sched[$];
    logic [15:0] mq[$];
    logic [15:0] m_cmd    = 16'h0;
    logic        m_strobe = 1'b0;
    logic        m_ovf    = 1'b0;
    int          cyc      = 0;

    always @(posedge clk_80mhz) begin
        bit   m_pop;
        bit   ovf_set;
        ev_t  ev;
        if (rst_n) begin
            cyc++;
            m_pop    = (mq.size() != 0) && wr_ready;
            m_strobe = 1'b0;
            ovf_set  = 1'b0;
            if (m_pop) void'(mq.pop_front());
            if (sched.size() != 0 && sched[0].cyc == cyc) begin
                ev = sched.pop_front();
                if (ev.cle) begin
                    m_cmd    = ev.d;
                    m_strobe = 1'b1;
                    if (ev.d == FLUSH) mq.delete();
                end else if (mq.size() < DEPTH) begin
                    mq.push_back(ev.d);
                end else begin
                    ovf_set = 1'b1;
                end
            end
            m_ovf = ovf_set | (m_ovf & ~ovf_clear);
        end
    end

    always @(negedge rst_n) begin
        mq.delete();
        sched.delete();
        m_cmd    = 16'h0;
        m_strobe = 1'b0;
        m_ovf    = 1'b0;
    end

    always @(negedge clk_80mhz) begin
        if (rst_n && chk_on) begin
            chk("wr_valid", 32'(wr_valid), 32'(mq.size() != 0));
            chk("wr_data", 32'(wr_data),
                32'((mq.size() != 0) ? mq[0] : 16'h0));
            chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
            chk("cmd_code", 32'(cmd_code), 32'(m_cmd));
            chk("cmd_strobe", 32'(cmd_strobe), 32'(m_strobe));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // One FSMC write: nwe low for lo cycles, then high for hi cycles.
    // cmt is the edge count after which the commit is visible.
    task automatic write_word(input logic c, input logic [15:0] d,
                              input int lo, input int hi,
                              input bit pop_cmt, output int cmt);
        ev_t ev;
        @(negedge clk_80mhz);
        fsmc_cle  = c;
        fsmc_d_in = d;
        fsmc_nwe  = 1'b0;
        repeat (lo) @(negedge clk_80mhz);
        fsmc_nwe = 1'b1;
        cmt = cyc + 1 + 3;
        if (lo >= 3) begin
            ev.cyc = cmt;
            ev.cle = c;
            ev.d   = d;
            sched.push_back(ev);
        end
        for (int h = 0; h < hi; h++) begin
            @(negedge clk_80mhz);
            if (pop_cmt) wr_ready = (cyc == cmt - 1);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk_80mhz);
            #1;
        end
    endtask

    task automatic drain(input int n);
        @(negedge clk_80mhz);
        wr_ready = 1'b1;
        repeat (n) @(negedge clk_80mhz);
        wr_ready = 1'b0;
    endtask

    int cmt;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk_80mhz);
        #1;
        chk("rst wr_valid", 32'(wr_valid), 32'h0);
        chk("rst wr_data", 32'(wr_data), 32'h0);
        chk("rst level", 32'(fifo_level), 32'h0);
        chk("rst cmd_code", 32'(cmd_code), 32'h0);
        chk("rst strobe", 32'(cmd_strobe), 32'h0);
        chk("rst overflow", 32'(overflow), 32'h0);
        @(negedge clk_80mhz);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        repeat (3) @(negedge clk_80mhz);

        // Data write with latency boundary
        write_word(1'b0, 16'h0ABC, 5, 2, 1'b0, cmt);
        wait_until(cmt - 1);
        chk("lat N+2 valid", 32'(wr_valid), 32'h0);
        wait_until(cmt);
        chk("lat N+3 valid", 32'(wr_valid), 32'h1);
        chk("data0 head", 32'(wr_data), 32'h0ABC);
        chk("data0 level", 32'(fifo_level), 32'h1);

        // Command word
        write_word(1'b1, 16'h0005, 4, 3, 1'b0, cmt);
        wait_until(cmt);
        chk("cmd strobe", 32'(cmd_strobe), 32'h1);
        chk("cmd code", 32'(cmd_code), 32'h0005);
        chk("cmd level", 32'(fifo_level), 32'h1);
        wait_until(cmt + 1);
        chk("cmd strobe end", 32'(cmd_strobe), 32'h0);

        // Pop, then wr_ready held while empty
        drain(4);
        repeat (2) @(negedge clk_80mhz);
        chk("drain level", 32'(fifo_level), 32'h0);

        // Overflow: 17 writes, nothing consumed
        for (int i = 0; i < 17; i++) begin
            write_word(1'b0, 16'h1000 + 16'(i), 3, 3, 1'b0, cmt);
        end
        wait_until(cmt);
        chk("ovf level", 32'(fifo_level), 32'd16);
        chk("ovf flag", 32'(overflow), 32'h1);
        chk("ovf head", 32'(wr_data), 32'h1000);
        @(negedge clk_80mhz);
        ovf_clear = 1'b1;
        @(negedge clk_80mhz);
        ovf_clear = 1'b0;
        #1;
        chk("ovf cleared", 32'(overflow), 32'h0);

        // Full FIFO with a pop on the commit edge
        write_word(1'b0, 16'h2000, 3, 5, 1'b1, cmt);
        chk("fullpop level", 32'(fifo_level), 32'd16);
        chk("fullpop ovf", 32'(overflow), 32'h0);
        chk("fullpop head", 32'(wr_data), 32'h1001);
        drain(20);
        repeat (2) @(negedge clk_80mhz);
        chk("fullpop drained", 32'(fifo_level), 32'h0);

        // Flush with three words queued
        for (int i = 0; i < 3; i++) begin
            write_word(1'b0, 16'h3001 + 16'(i), 3, 3, 1'b0, cmt);
        end
        wait_until(cmt);
        chk("preflush level", 32'(fifo_level), 32'd3);
        write_word(1'b1, FLUSH, 3, 3, 1'b0, cmt);
        wait_until(cmt);
        chk("flush level", 32'(fifo_level), 32'h0);
        chk("flush valid", 32'(wr_valid), 32'h0);
        chk("flush code", 32'(cmd_code), 32'hC1EA);

        // One-cycle glitch
        write_word(1'b0, 16'h4444, 1, 8, 1'b0, cmt);
        chk("glitch level", 32'(fifo_level), 32'h0);

        // Reset during a LOW phase, with a word already queued
        write_word(1'b0, 16'h1234, 3, 3, 1'b0, cmt);
        wait_until(cmt);
        chk("prerst level", 32'(fifo_level), 32'h1);
        @(negedge clk_80mhz);
        fsmc_cle  = 1'b0;
        fsmc_d_in = 16'hDEAD;
        fsmc_nwe  = 1'b0;
        repeat (4) @(negedge clk_80mhz);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst valid", 32'(wr_valid), 32'h0);
        chk("midrst data", 32'(wr_data), 32'h0);
        chk("midrst level", 32'(fifo_level), 32'h0);
        chk("midrst code", 32'(cmd_code), 32'h0);
        chk("midrst strobe", 32'(cmd_strobe), 32'h0);
        chk("midrst ovf", 32'(overflow), 32'h0);
        repeat (3) @(negedge clk_80mhz);
        rst_n = 1'b1;
        @(negedge clk_80mhz);
        fsmc_nwe = 1'b1;
        repeat (10) @(negedge clk_80mhz);
        #1;
        chk("postrst level", 32'(fifo_level), 32'h0);
        chk("postrst strobe", 32'(cmd_strobe), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fsmc_write_rx.md
FSMC_WRITE_RX -- requirements
Module: fsmc_write_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning the receive FIFO depth in words (power of 2, 4..256).
REQ-002 SHALL have parameter FLUSH_CMD, default 16'hC1EA, meaning the command word that empties the FIFO.
REQ-003 SHALL have port clk_80mhz, input, 1 bit: the single clock (PLL 80 MHz); all logic is in this domain.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port fsmc_nwe, input, 1 bit: FSMC_NWE write strobe from the MCU, active low, asynchronous to clk_80mhz.
REQ-006 SHALL have port fsmc_cle, input, 1 bit: word type, 1 = command and 0 = data, valid while fsmc_nwe is low.
REQ-007 SHALL have port fsmc_d_in, input, 16 bits: input side of the FSMC_D bus; this block never drives the bus.
REQ-008 SHALL have port wr_data, output, 16 bits: FIFO head word (first-word fall-through).
REQ-009 SHALL have port wr_valid, output, 1 bit: FIFO not empty.
REQ-010 SHALL have port wr_ready, input, 1 bit: consumer accepts the head word.
REQ-011 SHALL have port cmd_code, output, 16 bits: last received command word.
REQ-012 SHALL have port cmd_strobe, output, 1 bit: one-cycle pulse when cmd_code updates.
REQ-013 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1 bits: number of words held.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag meaning a data word was dropped.
REQ-015 SHALL have port ovf_clear, input, 1 bit: clears overflow.

Function
REQ-016 SHALL pass fsmc_nwe, fsmc_cle and fsmc_d_in through 2-stage synchronizers of equal depth, giving nwe_s, cle_s and d_s.
REQ-017 SHALL implement an FSM with states IDLE, LOW and COMMIT.
REQ-018 SHALL in IDLE move to LOW when nwe_s = 0, clearing low_cnt.
REQ-019 SHALL in LOW, on every cycle, latch d_s and cle_s and saturate-increment a 2-bit low_cnt.
REQ-020 SHALL in LOW, when nwe_s = 1, go to COMMIT if low_cnt >= 2, otherwise return to IDLE and discard the strobe as a glitch.
REQ-021 SHALL in COMMIT act for exactly one cycle and then return to IDLE; a new falling edge is only honoured from IDLE.
REQ-022 SHALL, for a commit with latched cle = 1, load cmd_code and pulse cmd_strobe for one cycle; the word SHALL NOT enter the FIFO.
REQ-023 SHALL, when the committed command equals FLUSH_CMD, also empty the FIFO in that same cycle (fifo_level = 0, wr_valid = 0 on the next cycle).
REQ-024 SHALL, for a commit with latched cle = 0 when the FIFO is not full, push the word.
REQ-025 SHALL, for a data commit when the FIFO is full, drop the word and set overflow; FIFO contents are unchanged.
REQ-026 SHALL, on a push into a full FIFO while wr_valid & wr_ready is true in the same cycle, perform both pop and push with no overflow and an unchanged level.
REQ-027 SHALL pop the FIFO when wr_valid & wr_ready; wr_ready is ignored while the FIFO is empty.
REQ-028 SHALL give flush priority over a same-cycle pop.
REQ-029 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, with fifo_level ranging 0..FIFO_DEPTH.
REQ-030 SHALL hold overflow set until ovf_clear; if overflow is set and cleared in the same cycle, set wins.
REQ-031 SHALL meet this latency: with the fsmc_nwe rising edge at the pin before clk edge N, the push or cmd_strobe occurs at edge N+3 and wr_valid is high from edge N+3.
REQ-032 SHALL require fsmc_nwe low >= 3 clk cycles (37.5 ns) and high >= 3 clk cycles for guaranteed capture; shorter pulses may be dropped but SHALL never corrupt the FIFO.
REQ-033 SHALL require data and cle setup >= 1 clk before, and hold >= 1 clk after, the fsmc_nwe rising edge; the captured word is the last d_s value sampled in LOW.

Reset
REQ-034 SHALL, while rst_n = 0 (asynchronous), force FSM = IDLE, FIFO empty, wr_valid = 0, wr_data = 0, fifo_level = 0, cmd_code = 0, cmd_strobe = 0, overflow = 0, and all synchronizer flops to 1 for nwe and 0 for the others.
REQ-035 SHALL discard a write in progress at reset assertion; after release, a strobe already low SHALL be captured only if it is still low for >= 2 synchronized cycles.
REQ-036 SHALL apply reset release synchronously to clk_80mhz at the integration level; the block takes no other reset input.

Verification
REQ-037 SHALL verify a data write: cle = 0, d = 16'h0ABC, nwe low for 5 cycles, wr_ready = 0 -> wr_valid = 1, wr_data = 16'h0ABC, fifo_level = 1 at N+3.
REQ-038 SHALL verify a command: cle = 1, d = 16'h0005 -> cmd_strobe high for 1 cycle, cmd_code = 16'h0005, fifo_level unchanged.
REQ-039 SHALL verify overflow: 17 data writes with wr_ready = 0 -> fifo_level = 16, overflow = 1, head = first word; ovf_clear -> overflow = 0.
REQ-040 SHALL verify full with simultaneous pop: FIFO full, wr_ready = 1 during the 17th commit -> level stays 16, overflow = 0, and order is preserved.
REQ-041 SHALL verify flush: 3 words queued, then command 16'hC1EA -> fifo_level = 0, wr_valid = 0, cmd_code = 16'hC1EA.
REQ-042 SHALL verify a glitch and reset mid-write: a 1-cycle nwe low pulse -> no push; rst_n low during a LOW phase -> all outputs at reset values and no push after release.
